// File: rtl/lvds_link_pkg.sv
// Shared types and helpers for the LVDS link tester: per-link state
// encoding, training-word construction and saturating increment.
package lvds_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAIL  = 2'd3
  } link_state_e;

  // Widest link word the training-word builder supports.
  localparam int MAX_WORD_W = 64;

  // Replicates the training byte into every DESER-bit slice of the word.
  // Only the low DESER bits of the byte are used; if DESER > 8 the upper
  // bits of each slice are zero.
  function automatic logic [MAX_WORD_W-1:0] build_train_word(
    input logic [7:0] train_byte,
    input int         lanes,
    input int         deser
  );
    logic [MAX_WORD_W-1:0] word;
    int                    slice_bit;
    word = '0;
    for (int b = 0; b < MAX_WORD_W; b++) begin
      if (b < lanes * deser) begin
        slice_bit = b % deser;
        if (slice_bit < 8) word[b] = train_byte[slice_bit[2:0]];
      end
    end
    return word;
  endfunction

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] value,
    input logic [31:0] max_value
  );
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/lvds_link_tester_if.sv
// Bundle of the fabric-side control and SERDES parallel-side signals of
// the link tester. master = tester, slave = SERDES / surrounding fabric.
interface lvds_link_tester_if #(
  parameter int NUM_LINKS = 2,
  parameter int WORD_W    = 16,
  parameter int ERR_W     = 16
);
  logic                        start;
  logic                        echo_mode;
  logic [NUM_LINKS*WORD_W-1:0] tx_data;
  logic [NUM_LINKS-1:0]        tx_align_done;
  logic [NUM_LINKS*WORD_W-1:0] rx_data;
  logic [NUM_LINKS-1:0]        rx_align_done;
  logic [NUM_LINKS-1:0]        link_up;
  logic [NUM_LINKS*ERR_W-1:0]  err_count;
  logic [7:0]                  led_out;

  modport master (
    input  start, echo_mode, tx_align_done, rx_data,
    output tx_data, rx_align_done, link_up, err_count, led_out
  );

  modport slave (
    output start, echo_mode, tx_align_done, rx_data,
    input  tx_data, rx_align_done, link_up, err_count, led_out
  );
endinterface

// File: rtl/lvds_link_channel.sv
// One LVDS link: training handshake, counter-pattern generator and
// self-synchronising checker, echo path, and saturating error counter.
module lvds_link_channel
  import lvds_link_pkg::*;
#(
  parameter int         LANES      = 2,
  parameter int         DESER      = 8,
  parameter logic [7:0] TRAIN_BYTE = 8'hA5,
  parameter int         LOCK_COUNT = 16,
  parameter int         TIMEOUT    = 2**20,
  parameter int         ERR_W      = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic                   start_i,
  input  logic                   echo_mode_i,
  input  logic                   tx_align_done_i,
  input  logic [LANES*DESER-1:0] rx_data_i,
  output logic [LANES*DESER-1:0] tx_data_o,
  output logic                   rx_align_done_o,
  output logic                   link_up_o,
  output logic [ERR_W-1:0]       err_count_o,
  output logic                   err_flag_o
);

  localparam int WORD_W  = LANES * DESER;
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  localparam logic [WORD_W-1:0]  TRAIN_WORD = WORD_W'(build_train_word(TRAIN_BYTE, LANES, DESER));
  localparam logic [MATCH_W-1:0] LOCK_M     = MATCH_W'(LOCK_COUNT);
  localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(TIMEOUT);
  localparam logic [31:0]        ERR_MAX    = 32'((64'd1 << ERR_W) - 64'd1);

  link_state_e        state_q;
  logic [WORD_W-1:0]  tx_q;
  logic [WORD_W-1:0]  prev_rx_q;
  logic [MATCH_W-1:0] match_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [ERR_W-1:0]   err_q;
  logic               rx_align_q;
  logic               link_up_q;
  logic               err_flag_q;
  logic               echo_q;
  logic               first_q;

  logic [WORD_W-1:0]  rx_exp;
  logic               mismatch;
  logic [ERR_W-1:0]   err_d;
  logic [MATCH_W-1:0] match_d;
  logic [TMO_W-1:0]   tmo_d;

  // Checker compare and counter next-values.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    rx_exp   = prev_rx_q + WORD_W'(1);
    mismatch = (state_q == ST_RUN) && !echo_q && !first_q &&
               (rx_data_i != TRAIN_WORD) && (rx_data_i != rx_exp);
    err_d    = mismatch ? ERR_W'(sat_inc(32'(err_q), ERR_MAX)) : err_q;
    match_d  = (rx_data_i == TRAIN_WORD) ? MATCH_W'(sat_inc(32'(match_q), 32'(LOCK_COUNT))) : '0;
    tmo_d    = tmo_q + TMO_W'(1);
  end

  // Link FSM with registered outputs; start=0 overrides everything but reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values; later assignments in this block override earlier defaults.
  always_ff @(posedge clk_clk) begin
    // NOTE: synchronous reset of every register; there is no storage array here that would be left unreset.
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      prev_rx_q  <= '0;
      match_q    <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      rx_align_q <= 1'b0;
      link_up_q  <= 1'b0;
      err_flag_q <= 1'b0;
      echo_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      prev_rx_q <= rx_data_i;
      first_q   <= 1'b0;
      // A mismatch counts even if the link drops or stops in the same cycle.
      err_q     <= err_d;
      if (mismatch) err_flag_q <= 1'b1;

      if (!start_i) begin
        state_q    <= ST_IDLE;
        tx_q       <= '0;
        rx_align_q <= 1'b0;
        link_up_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_TRAIN;
            echo_q     <= echo_mode_i;
            match_q    <= '0;
            tmo_q      <= '0;
            err_q      <= '0;
            err_flag_q <= 1'b0;
            rx_align_q <= 1'b0;
            tx_q       <= TRAIN_WORD;
          end
          ST_TRAIN: begin
            match_q <= match_d;
            tmo_q   <= tmo_d;
            if (match_q == LOCK_M) rx_align_q <= 1'b1;
            if (tmo_d == TMO_LIMIT) begin
              state_q    <= ST_FAIL;
              tx_q       <= '0;
              rx_align_q <= 1'b0;
              err_flag_q <= 1'b1;
            end else if (rx_align_q && tx_align_done_i) begin
              state_q   <= ST_RUN;
              link_up_q <= 1'b1;
              first_q   <= 1'b1;
              tx_q      <= echo_q ? rx_data_i : '0;
            end else begin
              tx_q <= TRAIN_WORD;
            end
          end
          ST_RUN: begin
            if (!tx_align_done_i) begin
              state_q    <= ST_TRAIN;
              link_up_q  <= 1'b0;
              rx_align_q <= 1'b0;
              match_q    <= '0;
              tmo_q      <= '0;
              tx_q       <= TRAIN_WORD;
            end else begin
              tx_q <= echo_q ? rx_data_i : tx_q + WORD_W'(1);
            end
          end
          ST_FAIL: begin
            tx_q       <= '0;
            link_up_q  <= 1'b0;
            err_flag_q <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_data_o       = tx_q;
  assign rx_align_done_o = rx_align_q;
  assign link_up_o       = link_up_q;
  assign err_count_o     = err_q;
  assign err_flag_o      = err_flag_q;

endmodule

// File: rtl/lvds_link_tester.sv
// Top level: NUM_LINKS independent link channels plus status LED packing.
module lvds_link_tester #(
  parameter int         NUM_LINKS  = 2,
  parameter int         LANES      = 2,
  parameter int         DESER      = 8,
  parameter logic [7:0] TRAIN_BYTE = 8'hA5,
  parameter int         LOCK_COUNT = 16,
  parameter int         TIMEOUT    = 2**20,
  parameter int         ERR_W      = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  lvds_link_tester_if.master  bus
);

  localparam int WORD_W = LANES * DESER;

  logic [WORD_W-1:0] tx_arr    [NUM_LINKS];
  logic [ERR_W-1:0]  err_arr   [NUM_LINKS];
  logic              align_arr [NUM_LINKS];
  logic              up_arr    [NUM_LINKS];
  logic              flag_arr  [NUM_LINKS];

  logic [NUM_LINKS*WORD_W-1:0] tx_data_w;
  logic [NUM_LINKS*ERR_W-1:0]  err_w;
  logic [NUM_LINKS-1:0]        rx_align_w;
  logic [NUM_LINKS-1:0]        link_up_w;
  logic [7:0]                  led_w;

  for (genvar g = 0; g < NUM_LINKS; g++) begin : g_link
    lvds_link_channel #(
      .LANES      (LANES),
      .DESER      (DESER),
      .TRAIN_BYTE (TRAIN_BYTE),
      .LOCK_COUNT (LOCK_COUNT),
      .TIMEOUT    (TIMEOUT),
      .ERR_W      (ERR_W)
    ) u_channel (
      .clk_clk         (clk_clk),
      .reset_reset_n   (reset_reset_n),
      .start_i         (bus.start),
      .echo_mode_i     (bus.echo_mode),
      .tx_align_done_i (bus.tx_align_done[g]),
      .rx_data_i       (bus.rx_data[g*WORD_W +: WORD_W]),
      .tx_data_o       (tx_arr[g]),
      .rx_align_done_o (align_arr[g]),
      .link_up_o       (up_arr[g]),
      .err_count_o     (err_arr[g]),
      .err_flag_o      (flag_arr[g])
    );
  end

  // Pack per-link results; LEDs: [i] link up, [4+i] sticky error.
  always_comb begin
    tx_data_w  = '0;
    err_w      = '0;
    rx_align_w = '0;
    link_up_w  = '0;
    led_w      = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      tx_data_w[i*WORD_W +: WORD_W] = tx_arr[i];
      err_w[i*ERR_W +: ERR_W]       = err_arr[i];
      rx_align_w[i]                 = align_arr[i];
      link_up_w[i]                  = up_arr[i];
      led_w[i]                      = up_arr[i];
      led_w[4+i]                    = flag_arr[i];
    end
  end

  assign bus.tx_data       = tx_data_w;
  assign bus.err_count     = err_w;
  assign bus.rx_align_done = rx_align_w;
  assign bus.link_up       = link_up_w;
  assign bus.led_out       = led_w;

endmodule

// File: tb/tb_lvds_link_tester.sv
// Bench for lvds_link_tester: external loopback with optional generator,
// fixed-word and bit-flip overrides on rx, and tx_align_done forcing.
// Expectations are queued with the cycle they fall due; a monitor
// compares them against the DUT on the falling edge.
module tb_lvds_link_tester;

  localparam int NUM_LINKS = 2;
  localparam int WORD_W    = 16;
  localparam int ERR_W     = 16;
  localparam logic [1:0] SRC_LOOP  = 2'd0;
  localparam logic [1:0] SRC_GEN   = 2'd1;
  localparam logic [1:0] SRC_FIXED = 2'd2;

  typedef enum int {F_TX0, F_TX1, F_RXA, F_LUP, F_ERR0, F_ERR1, F_LED} field_e;
  typedef struct {
    int          due;
    field_e      fld;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  lvds_link_tester_if #(.NUM_LINKS(NUM_LINKS), .WORD_W(WORD_W), .ERR_W(ERR_W)) bus ();

  lvds_link_tester #(
    .NUM_LINKS  (NUM_LINKS),
    .LANES      (2),
    .DESER      (8),
    .TRAIN_BYTE (8'hA5),
    .LOCK_COUNT (16),
    .TIMEOUT    (64),
    .ERR_W      (ERR_W)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus)
  );

  // Far-end model: loopback, generator or fixed word, optionally bit-flipped.
  logic [1:0]  rx_src    [2];
  logic [15:0] gen_base  [2];
  logic [15:0] fixed_val [2];
  logic [15:0] flip      [2];
  logic [1:0]  tad_force_en;
  logic [1:0]  tad_force_val;
  logic [31:0] rx_w;

  always_comb begin
    rx_w = '0;
    for (int i = 0; i < 2; i++) begin
      case (rx_src[i])
        SRC_GEN:   rx_w[i*16 +: 16] = (gen_base[i] + cyc[15:0]) ^ flip[i];
        SRC_FIXED: rx_w[i*16 +: 16] = fixed_val[i] ^ flip[i];
        default:   rx_w[i*16 +: 16] = bus.tx_data[i*16 +: 16] ^ flip[i];
      endcase
    end
  end

  assign bus.rx_data       = rx_w;
  assign bus.tx_align_done = (bus.rx_align_done & ~tad_force_en) | (tad_force_val & tad_force_en);

  // Scoreboard
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_at(input int due, input field_e fld, input logic [31:0] exp, input string name);
    exp_t e;
    e.due = due; e.fld = fld; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] pick(input field_e f);
    case (f)
      F_TX0:   return {16'h0, bus.tx_data[15:0]};
      F_TX1:   return {16'h0, bus.tx_data[31:16]};
      F_RXA:   return {30'h0, bus.rx_align_done};
      F_LUP:   return {30'h0, bus.link_up};
      F_ERR0:  return {16'h0, bus.err_count[15:0]};
      F_ERR1:  return {16'h0, bus.err_count[31:16]};
      default: return {24'h0, bus.led_out};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input bit late);
    n_tests++;
    if (late || act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h%s", name, cyc, act, exp, late ? " (late)" : "");
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  initial begin
    forever begin
      @(negedge clk_clk);
      #1;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].due <= cyc) begin
          check(sb[k].name, pick(sb[k].fld), sb[k].exp, sb[k].due < cyc);
          sb.delete(k);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin : stim
    int c;
    bus.start = 1'b0;
    bus.echo_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_src[i] = SRC_LOOP; gen_base[i] = '0; fixed_val[i] = '0; flip[i] = '0;
    end
    tad_force_en  = 2'b00;
    tad_force_val = 2'b00;
    reset_reset_n = 1'b0;
    tick(2);

    // Reset state, then training with loopback
    c = cyc;
    expect_at(c, F_TX0, 0, "rst_tx0");
    expect_at(c, F_TX1, 0, "rst_tx1");
    expect_at(c, F_RXA, 0, "rst_rx_align");
    expect_at(c, F_LUP, 0, "rst_link_up");
    expect_at(c, F_ERR0, 0, "rst_err0");
    expect_at(c, F_LED, 0, "rst_led");
    reset_reset_n = 1'b1;
    bus.start = 1'b1;
    expect_at(c+1,  F_TX0, 32'hA5A5, "train_word0");
    expect_at(c+1,  F_TX1, 32'hA5A5, "train_word1");
    expect_at(c+17, F_RXA, 0, "lock_not_before_17");
    expect_at(c+18, F_RXA, 3, "lock_after_17");
    expect_at(c+18, F_LUP, 0, "not_up_yet");
    expect_at(c+19, F_LUP, 3, "link_up_both");
    expect_at(c+19, F_TX0, 0, "run_first_word");
    expect_at(c+19, F_LED, 8'h03, "led_up");
    expect_at(c+20, F_TX0, 1, "run_second_word");
    tick(19);

    // Generator on rx, starting during the unchecked first RUN cycle
    for (int i = 0; i < 2; i++) begin
      gen_base[i] = 16'hFE00 - cyc[15:0];
      rx_src[i]   = SRC_GEN;
    end
    tick(1000);
    expect_at(cyc, F_ERR0, 0, "no_err0_across_wrap");
    expect_at(cyc, F_ERR1, 0, "no_err1_across_wrap");
    expect_at(cyc, F_LED, 8'h03, "led_clean");
    expect_at(cyc, F_TX0, 32'h03E8, "tx_count_1000");

    // Single-cycle bit-3 flip on link 1
    c = cyc;
    flip[1] = 16'h0008;
    expect_at(c+1, F_ERR1, 1, "flip1_bad_word");
    expect_at(c+2, F_ERR1, 2, "flip1_next_word");
    expect_at(c+2, F_ERR0, 0, "link0_unaffected");
    expect_at(c+2, F_LED, 8'h23, "led_err1");
    tick(1);
    flip[1] = 16'h0000;
    tick(2);

    // Same on link 0 so the link-loss check has a non-zero count to keep
    c = cyc;
    flip[0] = 16'h0008;
    expect_at(c+2, F_ERR0, 2, "flip0_count");
    expect_at(c+2, F_LED, 8'h33, "led_err_both");
    tick(1);
    flip[0] = 16'h0000;
    tick(2);

    // Link loss on link 0
    c = cyc;
    tad_force_en = 2'b01;
    expect_at(c+1, F_TX0, 32'hA5A5, "loss_train_word");
    expect_at(c+1, F_LUP, 2'b10, "loss_link_up");
    expect_at(c+1, F_RXA, 2'b10, "loss_rx_align");
    expect_at(c+1, F_ERR0, 2, "loss_err0_kept");
    expect_at(c+1, F_ERR1, 2, "loss_err1_kept");
    expect_at(c+1, F_LED, 8'h32, "loss_led");
    expect_at(c+17, F_RXA, 2'b10, "relock_not_yet");
    expect_at(c+18, F_RXA, 2'b11, "relock");
    expect_at(c+19, F_LUP, 2'b11, "relink_up");
    expect_at(c+19, F_TX0, 0, "relink_first_word");
    expect_at(c+25, F_ERR0, 2, "err0_after_retrain");
    expect_at(c+25, F_LED, 8'h33, "led_after_retrain");
    tick(1);
    rx_src[0] = SRC_LOOP;
    tick(1);
    tad_force_en = 2'b00;
    tick(23);

    // Timeout to FAIL with far end never aligning
    bus.start = 1'b0;
    tick(1);
    rx_src[0] = SRC_LOOP;
    rx_src[1] = SRC_LOOP;
    tad_force_en  = 2'b11;
    tad_force_val = 2'b00;
    bus.start = 1'b1;
    c = cyc;
    expect_at(c+1,  F_TX0, 32'hA5A5, "fail_run_training");
    expect_at(c+1,  F_ERR0, 0, "err0_cleared_on_train");
    expect_at(c+1,  F_ERR1, 0, "err1_cleared_on_train");
    expect_at(c+1,  F_LED, 0, "led_cleared_on_train");
    expect_at(c+18, F_RXA, 3, "fail_run_local_lock");
    expect_at(c+64, F_TX0, 32'hA5A5, "still_training_at_63");
    expect_at(c+64, F_LUP, 0, "no_link_without_far_end");
    expect_at(c+65, F_TX0, 0, "fail_tx0_zero");
    expect_at(c+65, F_TX1, 0, "fail_tx1_zero");
    expect_at(c+65, F_RXA, 0, "fail_rx_align");
    expect_at(c+65, F_LED, 8'h30, "fail_led");
    tick(66);
    bus.start = 1'b0;
    tick(1);

    // Back through IDLE into echo mode
    c = cyc;
    expect_at(c, F_TX0, 0, "idle_tx0");
    expect_at(c, F_LED, 8'h30, "idle_sticky_kept");
    tad_force_en = 2'b00;
    bus.echo_mode = 1'b1;
    bus.start = 1'b1;
    expect_at(c+1,  F_TX0, 32'hA5A5, "idle_to_train");
    expect_at(c+1,  F_LED, 0, "echo_led_cleared");
    expect_at(c+19, F_LUP, 3, "echo_link_up");
    expect_at(c+19, F_TX0, 32'hA5A5, "echo_first_word");
    expect_at(c+19, F_LED, 8'h03, "echo_led");
    tick(19);
    rx_src[0] = SRC_FIXED;
    fixed_val[0] = 16'h1234;
    expect_at(cyc+1, F_TX0, 32'h1234, "echo_1234");
    tick(1);
    fixed_val[0] = 16'h5678;
    expect_at(cyc+1, F_TX0, 32'h5678, "echo_5678");
    expect_at(cyc+1, F_TX1, 32'hA5A5, "echo_loop1");
    expect_at(cyc+2, F_ERR0, 0, "echo_no_check0");
    expect_at(cyc+2, F_ERR1, 0, "echo_no_check1");
    tick(2);

    // Reset mid-RUN
    reset_reset_n = 1'b0;
    rx_src[0] = SRC_LOOP;
    bus.echo_mode = 1'b0;
    tick(1);
    c = cyc;
    expect_at(c, F_TX0, 0, "mid_rst_tx0");
    expect_at(c, F_TX1, 0, "mid_rst_tx1");
    expect_at(c, F_RXA, 0, "mid_rst_rx_align");
    expect_at(c, F_LUP, 0, "mid_rst_link_up");
    expect_at(c, F_ERR0, 0, "mid_rst_err0");
    expect_at(c, F_ERR1, 0, "mid_rst_err1");
    expect_at(c, F_LED, 0, "mid_rst_led");
    reset_reset_n = 1'b1;
    expect_at(c+1,  F_TX0, 32'hA5A5, "retrain_word");
    expect_at(c+18, F_RXA, 3, "retrain_lock");
    expect_at(c+19, F_LUP, 3, "retrain_link_up");
    expect_at(c+19, F_TX0, 0, "retrain_first_word");
    expect_at(c+24, F_TX0, 5, "retrain_count");
    expect_at(c+29, F_ERR0, 0, "retrain_err0");
    expect_at(c+29, F_ERR1, 0, "retrain_err1");
    expect_at(c+29, F_LED, 8'h03, "retrain_led");
    tick(32);

    foreach (sb[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never compared (due cycle %0d)", sb[k].name, sb[k].due);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_link_tester.md
Name: lvds_link_tester

Overview:
- Parametrised successor to the two-FPGA LVDS echo component.
- Drives and checks the parallel (deserialised) side of NUM_LINKS independent LVDS links.
- Per link: training/alignment handshake, then either echo mode or counter-pattern generate/check mode, with per-link error counting and LED status.
- Sits between the Qsys fabric clock domain and the SERDES megafunctions; all SERDES words are synchronous to clk_clk.

Parameters:
NUM_LINKS, 2, number of links, legal 1..4
LANES, 2, LVDS lanes per link
DESER, 8, deserialisation factor; WORD_W = LANES*DESER bits per link word
TRAIN_BYTE, 8'hA5, per-DESER-slice training pattern, replicated across the word (low DESER bits used)
LOCK_COUNT, 16, consecutive training matches needed for rx lock
TIMEOUT, 2**20, TRAIN cycles before FAIL
ERR_W, 16, error counter width

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  synchronous active-low reset
start  in  1  level; 1 = run links, 0 = return all links to IDLE
echo_mode  in  1  0 = pattern generate/check, 1 = echo rx to tx; sampled on IDLE->TRAIN
tx_data  out  NUM_LINKS*WORD_W  parallel tx word per link (link i at [i*WORD_W +: WORD_W])
tx_align_done  in  NUM_LINKS  far-end receiver lock indication per link
rx_data  in  NUM_LINKS*WORD_W  parallel rx word per link
rx_align_done  out  NUM_LINKS  local receiver lock per link
link_up  out  NUM_LINKS  link in RUN
err_count  out  NUM_LINKS*ERR_W  saturating pattern-error count per link
led_out  out  8  status LEDs

Behaviour:
- Reset (reset_reset_n=0 at a clk_clk edge): every link goes to IDLE; tx_data=0, rx_align_done=0, link_up=0, err_count=0, led_out=0, sticky flags cleared.
- Per-link FSM states: IDLE, TRAIN, RUN, FAIL. All outputs registered.
- IDLE: tx_data=0. On start=1, latch echo_mode, clear timeout and match counters, and go to TRAIN.
- TRAIN:
  - tx_data = TRAIN_WORD (TRAIN_BYTE replicated).
  - Match counter increments when rx_data==TRAIN_WORD and resets to 0 otherwise; it saturates at LOCK_COUNT.
  - rx_align_done is set the cycle after the counter reaches LOCK_COUNT. It stays set until the link leaves RUN/TRAIN.
  - Go to RUN when rx_align_done=1 and tx_align_done=1 in the same cycle.
  - Timeout counter increments every TRAIN cycle. When it reaches TIMEOUT with no RUN transition, go to FAIL.
- RUN, pattern mode:
  - tx_data is a WORD_W-bit counter. It starts at 0 on the first RUN cycle and increments by 1 per cycle, wrapping mod 2^WORD_W.
  - Checker is self-synchronising: it compares rx_data against prev_rx+1 (mod 2^WORD_W), where prev_rx is the previous cycle's rx_data.
  - The first RUN cycle and any rx word equal to TRAIN_WORD are not checked.
  - On mismatch, err_count increments, saturating at 2^ERR_W-1, and the sticky error flag is set.
- RUN, echo mode: tx_data = rx_data registered, so 1-cycle latency. No checking; err_count holds.
- Link loss: in RUN, if tx_align_done falls, go to TRAIN. rx_align_done clears and counters clear; err_count and the sticky flag are preserved.
- FAIL: tx_data=0, link_up=0, sticky error flag set. Stays in FAIL until start=0, then goes to IDLE.
- start=0 in any state: go to IDLE next cycle. err_count and sticky flags are cleared only by reset or by an IDLE->TRAIN transition.
- link_up = (state==RUN), registered alongside the state.
- led_out: [i] = link_up[i] and [4+i] = sticky error flag[i] for i<NUM_LINKS; unused bits are 0.
- Simultaneous events: reset has priority over start=0, which has priority over FAIL/timeout, which has priority over the RUN transition. A mismatch in the same cycle as a tx_align_done fall still counts.

Decomposition:
- Shared package lvds_link_pkg: state enum (IDLE/TRAIN/RUN/FAIL), function build_train_word(TRAIN_BYTE, LANES, DESER), and a saturating-increment function.
- Sub-module lvds_link_channel: one link's FSM, generator, checker and counters.
- Top level: generate loop over NUM_LINKS, plus LED packing.

Test Plan:
- NUM_LINKS=2, WORD_W=16. Loop rx_data to tx_data externally with tx_align_done tied to rx_align_done, start=1, echo_mode=0 -> rx_align_done=1 exactly LOCK_COUNT+1 cycles after the first training word returns; link_up=2'b11; led_out=8'h03; err_count=0 after 1000 cycles including 16'hFFFF->0 wrap.
- RUN pattern mode: flip bit 3 of link 1 rx for one cycle -> link1 err_count=2 (bad word plus the following word); led_out[5]=1; link 0 unaffected.
- tx_align_done held 0 -> FAIL after TIMEOUT cycles (use TIMEOUT=64 in the bench); tx_data=0; drop start -> IDLE the next cycle.
- echo_mode=1 in RUN: rx_data=16'h1234 in cycle n -> tx_data=16'h1234 in cycle n+1; err_count unchanged.
- In RUN, drop tx_align_done on link 0 -> link 0 returns to TRAIN sending TRAIN_WORD 16'hA5A5; link_up[0]=0; err_count retained.
- Assert reset_reset_n=0 mid-RUN for one edge -> all outputs 0 on the next cycle; the FSM re-trains from IDLE.
